enigma_msg_sequencer: RTL and testbench
=======================================

Name: enigma_msg_sequencer

Overview:
- Front-end controller that sequences the three-rotor/reflector enigma core one character at a time.
- Accepts an ASCII byte stream over a valid/ready handshake and folds lowercase to uppercase.
- Letters: issues core_valid, waits for core_done, steps the rotors, then returns the ciphered ASCII byte over a second valid/ready handshake. Non-letters bypass the core unchanged.
- Also drives the core's configuration-load (set) phase and detects a hung core by timeout.

Parameters:
- SET_CYCLES, 2: number of cycles core_set is held high per configuration load (≥1).
- TIMEOUT_CYCLES, 64: maximum cycles spent in WAIT before the timeout fires (≥2).
- CNT_W, 16: width of char_count.

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cfg_load  in  1  one-cycle pulse: start configuration load; accepted only in IDLE or READY
- dec_mode  in  1  decrypt select; sampled on cfg_load, drives core_dec
- in_valid  in  1  input byte valid
- in_ready  out  1  sequencer can accept a byte
- in_data  in  8  ASCII input byte
- in_last  in  1  marks final byte of a message
- out_valid  out  1  output byte valid
- out_ready  in  1  downstream accepts the output byte
- out_data  out  8  ASCII output byte
- out_last  out  1  copy of in_last for this byte
- core_set  out  1  to core set
- core_en  out  1  to core en (rotor step enable)
- core_dec  out  1  to core dec
- core_valid  out  1  to core valid
- core_din  out  8  to core din: letter index 0..25
- core_dout  in  8  from core dout: letter index 0..25
- core_done  in  1  from core done
- busy  out  1  high in every state except IDLE and READY
- timeout_err  out  1  sticky; set on timeout, cleared by reset or cfg_load
- char_count  out  CNT_W  letters ciphered since last cfg_load; wraps at 2^CNT_W

Behaviour:
- Reset:
  - state=IDLE; all outputs 0; char_count=0; core_dec=0; timeout_err=0.
  - Reset mid-operation aborts with no output; any held byte is discarded.
- IDLE: in_ready=0. cfg_load -> SET.
- SET:
  - core_set=1 for exactly SET_CYCLES cycles, then -> READY.
  - On entry: core_dec latched from dec_mode; char_count=0; timeout_err=0.
  - cfg_load pulses during SET are ignored.
- READY:
  - in_ready=1.
  - cfg_load has priority over a simultaneous in_valid: -> SET, byte not accepted.
  - Else on in_valid (handshake): latch byte and in_last; lowercase 0x61–0x7A is folded by subtracting 0x20.
    - Letter 0x41–0x5A -> ISSUE.
    - Any other byte -> OUT with out_data = the byte unchanged (no core activity, no count).
- ISSUE: exactly one cycle; core_valid=1, core_din=byte-0x41 (held only this cycle; 0 otherwise) -> WAIT.
- WAIT:
  - Timer starts at 0 and increments each cycle.
  - core_done=1 -> capture out_data=core_dout+0x41; char_count+1 -> STEP.
  - Timer reaches TIMEOUT_CYCLES-1 without core_done -> timeout_err=1; out_data=0x3F ('?'); no count -> STEP.
  - core_done in the same cycle as timer expiry counts as done (no error).
- STEP: core_en=1 for exactly one cycle (rotors advance once per letter, including on timeout) -> OUT.
- OUT:
  - out_valid=1; out_data/out_last stable until out_ready.
  - On handshake -> READY. A new input byte is not accepted in the same cycle.
- core_done outside WAIT is ignored.
- core_en and core_set are never high together; core_valid is never high outside ISSUE.
- Latency for a letter with core done k cycles after ISSUE: out_valid rises k+2 cycles after ISSUE.
- Bypass latency: out_valid rises 1 cycle after the input handshake.

Test Plan:
- Config: reset, cfg_load with dec_mode=1 -> core_set high exactly 2 cycles; core_dec=1; READY with in_ready=1 on the 3rd cycle.
- Letter path: send 'b' (0x62); core model returns done with dout=5 three cycles after valid -> core_din=1; one core_en pulse; out_data=0x46 'F'; char_count=1.
- Bypass: send ' ' (0x20) with in_last=1 -> no core_valid/core_en; out_data=0x20, out_last=1 one cycle later; char_count unchanged.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid/out_data stable, in_ready=0; release -> next byte accepted the following cycle.
- Timeout: core never asserts done -> after 64 cycles in WAIT, timeout_err=1, one core_en pulse, out_data=0x3F; next cfg_load clears timeout_err.
- Priority/reset: cfg_load and in_valid in the same READY cycle -> byte not taken, SET entered. Reset asserted in WAIT -> IDLE next cycle, no out_valid.

Source files
------------

// File: rtl/enigma_msg_sequencer.sv
// enigma_msg_sequencer: byte-stream front end for the three-rotor enigma core.
// It folds lowercase to uppercase and sends letters through the core one at a
// time, stepping the rotors once per letter. Non-letters bypass the core.
// It also runs the core configuration-load phase and detects a hung core.
module enigma_msg_sequencer #(
  parameter int SET_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_load,
  input  logic             dec_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             core_set,
  output logic             core_en,
  output logic             core_dec,
  output logic             core_valid,
  output logic [7:0]       core_din,
  input  logic [7:0]       core_dout,
  input  logic             core_done,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] char_count
);

  localparam int SC_W = (SET_CYCLES > 1) ? $clog2(SET_CYCLES) : 1;
  localparam int TM_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_SET, S_READY, S_ISSUE, S_WAIT, S_STEP, S_OUT
  } state_t;

  state_t           state_q, state_d;
  logic [SC_W-1:0]  set_cnt_q, set_cnt_d;
  logic [TM_W-1:0]  timer_q, timer_d;
  logic [7:0]       byte_q, byte_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             dec_q, dec_d;
  logic             terr_q, terr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Case folding of the incoming byte and letter classification.
  logic [7:0] folded;
  logic       is_lower;
  logic       is_letter;
  assign is_lower  = (in_data >= 8'h61) && (in_data <= 8'h7A);
  assign folded    = is_lower ? (in_data - 8'h20) : in_data;
  assign is_letter = (folded >= 8'h41) && (folded <= 8'h5A);

  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign core_dec    = dec_q;
  assign timeout_err = terr_q;
  assign char_count  = count_q;

  // State and datapath registers; reset discards any byte in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      set_cnt_q  <= '0;
      timer_q    <= '0;
      byte_q     <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      dec_q      <= 1'b0;
      terr_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      set_cnt_q  <= set_cnt_d;
      timer_q    <= timer_d;
      byte_q     <= byte_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      dec_q      <= dec_d;
      terr_q     <= terr_d;
      count_q    <= count_d;
    end
  end

  // Next-state, datapath updates and state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    set_cnt_d  = set_cnt_q;
    timer_d    = timer_q;
    byte_d     = byte_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    dec_d      = dec_q;
    terr_d     = terr_q;
    count_d    = count_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    core_set   = 1'b0;
    core_en    = 1'b0;
    core_valid = 1'b0;
    core_din   = 8'h00;
    busy       = 1'b1;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (cfg_load) begin
          state_d   = S_SET;
          set_cnt_d = '0;
          dec_d     = dec_mode;
          count_d   = '0;
          terr_d    = 1'b0;
        end
      end
      S_SET: begin
        core_set = 1'b1;
        if (set_cnt_q == SC_W'(SET_CYCLES - 1)) begin
          state_d = S_READY;
        end else begin
          set_cnt_d = set_cnt_q + 1'b1;
        end
      end
      S_READY: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        // A configuration load wins over a byte offered in the same cycle.
        if (cfg_load) begin
          state_d   = S_SET;
          set_cnt_d = '0;
          dec_d     = dec_mode;
          count_d   = '0;
          terr_d    = 1'b0;
        end else if (in_valid) begin
          out_last_d = in_last;
          if (is_letter) begin
            byte_d  = folded;
            state_d = S_ISSUE;
          end else begin
            out_data_d = in_data;
            state_d    = S_OUT;
          end
        end
      end
      S_ISSUE: begin
        core_valid = 1'b1;
        core_din   = byte_q - 8'h41;
        timer_d    = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // Done on the expiry cycle still counts as a normal completion.
        if (core_done) begin
          out_data_d = core_dout + 8'h41;
          count_d    = count_q + CNT_W'(1);
          state_d    = S_STEP;
        end else if (timer_q == TM_W'(TIMEOUT_CYCLES - 1)) begin
          terr_d     = 1'b1;
          out_data_d = 8'h3F;
          state_d    = S_STEP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_STEP: begin
        core_en = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_READY;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_enigma_msg_sequencer.sv
// Directed testbench for enigma_msg_sequencer. Inputs are driven and outputs
// sampled on the falling clock edge; the core is emulated inline per scenario.
module tb_enigma_msg_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_load;
  logic        dec_mode;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        core_set;
  logic        core_en;
  logic        core_dec;
  logic        core_valid;
  logic [7:0]  core_din;
  logic [7:0]  core_dout;
  logic        core_done;
  logic        busy;
  logic        timeout_err;
  logic [15:0] char_count;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  enigma_msg_sequencer #(
    .SET_CYCLES(2),
    .TIMEOUT_CYCLES(64),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cfg_load(cfg_load),
    .dec_mode(dec_mode),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .core_set(core_set),
    .core_en(core_en),
    .core_dec(core_dec),
    .core_valid(core_valid),
    .core_din(core_din),
    .core_dout(core_dout),
    .core_done(core_done),
    .busy(busy),
    .timeout_err(timeout_err),
    .char_count(char_count)
  );

  // Wait (bounded) for out_valid, counting core_en / core_valid pulses seen.
  task automatic wait_out(input int max_cyc, output int cyc, output int en_cnt,
                          output int vld_cnt, output bit ok);
    cyc = 0; en_cnt = 0; vld_cnt = 0; ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      cyc++;
      if (core_en) en_cnt++;
      if (core_valid) vld_cnt++;
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Configuration load without checks; starts at a negedge in IDLE/READY.
  task automatic do_cfg(input logic dec);
    cfg_load = 1'b1; dec_mode = dec;
    @(negedge clk); cfg_load = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; cfg_load = 0; dec_mode = 0; in_valid = 0; in_data = 0;
    in_last = 0; out_ready = 0; core_dout = 0; core_done = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if ({in_ready, out_valid, busy, core_set, core_en, core_valid, core_dec, timeout_err} !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 00000000",
               {in_ready, out_valid, busy, core_set, core_en, core_valid, core_dec, timeout_err});
    end
    tests_run++;
    if ({char_count, out_data, core_din, out_last} !== 33'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got cnt=%0h out=%0h din=%0h last=%b expected all 0",
               char_count, out_data, core_din, out_last);
    end
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_in_ready: got %b expected 0", in_ready);
    end
    $display("[TB] reset done");
  endtask

  task automatic test_config;
    cfg_load = 1'b1; dec_mode = 1'b1;
    @(negedge clk); cfg_load = 1'b0; dec_mode = 1'b0;
    tests_run++;
    if ({core_set, core_dec, in_ready, busy} !== 4'b1101) begin
      tests_failed++;
      $display("FAIL cfg_set1: got set/dec/rdy/busy=%b expected 1101",
               {core_set, core_dec, in_ready, busy});
    end
    @(negedge clk);
    tests_run++;
    if ({core_set, core_en} !== 2'b10) begin
      tests_failed++;
      $display("FAIL cfg_set2: got set/en=%b expected 10", {core_set, core_en});
    end
    @(negedge clk);
    tests_run++;
    if ({core_set, in_ready, busy, core_dec} !== 4'b0101 || char_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL cfg_ready: got set/rdy/busy/dec=%b cnt=%0d expected 0101 cnt=0",
               {core_set, in_ready, busy, core_dec}, char_count);
    end
    $display("[TB] cfg_load dec_mode=1 -> READY");
  endtask

  task automatic test_letter;
    int en_cnt;
    en_cnt = 0;
    in_valid = 1'b1; in_data = 8'h62; in_last = 1'b0;
    @(negedge clk); in_valid = 1'b0;
    tests_run++;
    if ({core_valid, in_ready} !== 2'b10 || core_din !== 8'd1) begin
      tests_failed++;
      $display("FAIL letter_issue: got valid/rdy=%b din=%0d expected 10 din=1",
               {core_valid, in_ready}, core_din);
    end
    repeat (2) begin
      @(negedge clk);
      if (core_en) en_cnt++;
    end
    @(negedge clk); core_done = 1'b1; core_dout = 8'd5;
    if (core_en) en_cnt++;
    @(negedge clk); core_done = 1'b0; core_dout = 8'd0;
    if (core_en) en_cnt++;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL letter_early: got out_valid=%b expected 0", out_valid);
    end
    @(negedge clk);
    if (core_en) en_cnt++;
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 8'h46 || out_last !== 1'b0) begin
      tests_failed++;
      $display("FAIL letter_out: got v=%b data=%0h last=%b expected v=1 data=46 last=0",
               out_valid, out_data, out_last);
    end
    tests_run++;
    if (char_count !== 16'd1 || en_cnt !== 1) begin
      tests_failed++;
      $display("FAIL letter_count: got cnt=%0d en_pulses=%0d expected 1 1", char_count, en_cnt);
    end
    $display("[TB] letter in=62 out=%02h", out_data);
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    tests_run++;
    if ({out_valid, in_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL letter_hs: got v/rdy=%b expected 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_bypass;
    in_valid = 1'b1; in_data = 8'h20; in_last = 1'b1;
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 8'h20 || out_last !== 1'b1) begin
      tests_failed++;
      $display("FAIL bypass_out: got v=%b data=%0h last=%b expected 1 20 1",
               out_valid, out_data, out_last);
    end
    tests_run++;
    if ({core_valid, core_en} !== 2'b00 || char_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL bypass_core: got cv/en=%b cnt=%0d expected 00 cnt=1",
               {core_valid, core_en}, char_count);
    end
    $display("[TB] bypass in=20 out=%02h last=%b", out_data, out_last);
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    tests_run++;
    if ({out_valid, in_ready, core_en} !== 3'b010) begin
      tests_failed++;
      $display("FAIL bypass_hs: got v/rdy/en=%b expected 010", {out_valid, in_ready, core_en});
    end
  endtask

  task automatic test_backpressure;
    int bad;
    bad = 0;
    in_valid = 1'b1; in_data = 8'h21; in_last = 1'b0;
    @(negedge clk); in_data = 8'h2E;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || out_data !== 8'h21 || in_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    tests_run++;
    if (bad !== 0 || out_valid !== 1'b1 || out_data !== 8'h21) begin
      tests_failed++;
      $display("FAIL bp_hold: got %0d unstable cycles, v=%b data=%0h expected 0 1 21",
               bad, out_valid, out_data);
    end
    $display("[TB] backpressure in=21 out=%02h", out_data);
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    tests_run++;
    if ({out_valid, in_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL bp_release: got v/rdy=%b expected 01", {out_valid, in_ready});
    end
    @(negedge clk); in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 8'h2E) begin
      tests_failed++;
      $display("FAIL bp_next: got v=%b data=%0h expected 1 2e", out_valid, out_data);
    end
    $display("[TB] backpressure next in=2e out=%02h", out_data);
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_timeout;
    int cyc, en_cnt, vld_cnt;
    bit ok;
    in_valid = 1'b1; in_data = 8'h7A;
    @(negedge clk); in_valid = 1'b0;
    tests_run++;
    if (core_valid !== 1'b1 || core_din !== 8'd25) begin
      tests_failed++;
      $display("FAIL to_issue: got cv=%b din=%0d expected 1 25", core_valid, core_din);
    end
    wait_out(100, cyc, en_cnt, vld_cnt, ok);
    tests_run++;
    if (!ok || cyc !== 66 || en_cnt !== 1 || vld_cnt !== 0) begin
      tests_failed++;
      $display("FAIL to_timing: got ok=%b lat=%0d en=%0d cv=%0d expected 1 66 1 0",
               ok, cyc, en_cnt, vld_cnt);
    end
    tests_run++;
    if (out_data !== 8'h3F || timeout_err !== 1'b1 || char_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL to_result: got data=%0h err=%b cnt=%0d expected 3f 1 1",
               out_data, timeout_err, char_count);
    end
    $display("[TB] timeout in=7a out=%02h err=%b", out_data, timeout_err);
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    cfg_load = 1'b1; dec_mode = 1'b0;
    @(negedge clk); cfg_load = 1'b0;
    tests_run++;
    if ({timeout_err, core_dec, core_set} !== 3'b001 || char_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL to_clear: got err/dec/set=%b cnt=%0d expected 001 0",
               {timeout_err, core_dec, core_set}, char_count);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_done_at_expiry;
    in_valid = 1'b1; in_data = 8'h51;
    @(negedge clk); in_valid = 1'b0;
    tests_run++;
    if (core_din !== 8'd16) begin
      tests_failed++;
      $display("FAIL exp_issue: got din=%0d expected 16", core_din);
    end
    repeat (64) @(negedge clk);
    tests_run++;
    if ({busy, core_en, out_valid, timeout_err} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL exp_wait: got busy/en/v/err=%b expected 1000",
               {busy, core_en, out_valid, timeout_err});
    end
    core_done = 1'b1; core_dout = 8'd2;
    @(negedge clk); core_done = 1'b0; core_dout = 8'd0;
    tests_run++;
    if (core_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL exp_step: got core_en=%b expected 1", core_en);
    end
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 8'h43 || timeout_err !== 1'b0 || char_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL exp_result: got v=%b data=%0h err=%b cnt=%0d expected 1 43 0 1",
               out_valid, out_data, timeout_err, char_count);
    end
    $display("[TB] done-at-expiry in=51 out=%02h", out_data);
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_priority;
    cfg_load = 1'b1; dec_mode = 1'b1; in_valid = 1'b1; in_data = 8'h41;
    @(negedge clk); cfg_load = 1'b0; dec_mode = 1'b0; in_valid = 1'b0;
    tests_run++;
    if ({core_set, core_valid, out_valid, core_dec} !== 4'b1001 || char_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL prio_set: got set/cv/v/dec=%b cnt=%0d expected 1001 0",
               {core_set, core_valid, out_valid, core_dec}, char_count);
    end
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if ({in_ready, out_valid, core_valid} !== 3'b100) begin
      tests_failed++;
      $display("FAIL prio_ready: got rdy/v/cv=%b expected 100", {in_ready, out_valid, core_valid});
    end
    $display("[TB] priority cfg_load over in=41");
  endtask

  task automatic test_reset_in_wait;
    int bad;
    bad = 0;
    in_valid = 1'b1; in_data = 8'h61;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    tests_run++;
    if ({busy, in_ready, out_valid, core_dec} !== 4'b0000 || char_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL rst_wait: got busy/rdy/v/dec=%b cnt=%0d expected 0000 0",
               {busy, in_ready, out_valid, core_dec}, char_count);
    end
    core_done = 1'b1; core_dout = 8'd3;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || core_en !== 1'b0 || busy !== 1'b0) bad++;
    end
    core_done = 1'b0; core_dout = 8'd0;
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL rst_quiet: got %0d active cycles after reset expected 0", bad);
    end
    $display("[TB] reset in WAIT aborted in=61");
  endtask

  initial begin
    test_reset();
    test_config();
    test_letter();
    test_bypass();
    test_backpressure();
    test_timeout();
    test_done_at_expiry();
    test_priority();
    do_cfg(1'b0);
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
